// File: rtl/bist_pkg.sv
// Shared definitions for the BIST engine: FSM state encoding, default
// LFSR/MISR feedback masks for common widths, and a ceil(log2) helper
// that can be used in port widths.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_e;

    // Galois right-shift LFSR masks (maximal length)
    localparam logic [2:0] LFSR_TAPS_3 = 3'b110;
    localparam logic [3:0] LFSR_TAPS_4 = 4'b1100;

    // Galois left-shift MISR masks
    localparam logic [3:0] MISR_TAPS_4 = 4'b0011;
    localparam logic [7:0] MISR_TAPS_8 = 8'h1D;

    // Smallest r with 2**r >= v (0 for v <= 1)
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/misr_n.sv
// Multiple-input signature register.
//   clock  : rising-edge clock
//   reset  : synchronous active-high, clears the signature
//   clear  : synchronous clear (run start), higher priority than en
//   en     : compact din into the signature this edge
//   din    : M-bit response, zero-extended into the S-bit register
//   sig    : current signature
module misr_n
    import bist_pkg::*;
#(
    parameter int             S         = 4,
    parameter int             M         = 2,
    parameter logic [S-1:0]   MISR_TAPS = MISR_TAPS_4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    input  logic [M-1:0] din,
    output logic [S-1:0] sig
);

    logic [S-1:0] sig_q, sig_d;
    logic [S-1:0] din_ext;

    always_comb begin
        din_ext         = '0;
        din_ext[M-1:0]  = din;
    end

    always_comb begin
        sig_d = sig_q;
        if (clear) begin
            sig_d = '0;
        end else if (en) begin
            // shift left, fold the outgoing MSB back through the taps
            sig_d = {sig_q[S-2:0], 1'b0} ^ (sig_q[S-1] ? MISR_TAPS : '0) ^ din_ext;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) sig_q <= '0;
        else       sig_q <= sig_d;
    end

    assign sig = sig_q;

endmodule

// File: rtl/bist_engine.sv
// Built-in self-test engine sitting between functional inputs and a
// combinational DUT. In test mode an LFSR drives the DUT, the response is
// compacted into a MISR and compared once per run against GOLDEN.
//   clock, reset    : single clock, synchronous active-high reset
//   testmode        : 1 = BIST, 0 = functional (also aborts any run)
//   start           : level run request, sampled in IDLE
//   func_in         : functional DUT inputs
//   dut_in          : DUT inputs (LFSR in test mode, else func_in)
//   dut_out         : DUT response
//   signature       : current MISR contents
//   busy/done       : run in progress / result available
//   fault_detected  : signature != GOLDEN, valid while done
//   pattern_count   : patterns applied this run
module bist_engine
    import bist_pkg::*;
#(
    parameter int           N            = 3,
    parameter int           M            = 2,
    parameter int           S            = 4,
    parameter int           NUM_PATTERNS = 7,
    parameter logic [N-1:0] LFSR_TAPS    = LFSR_TAPS_3,
    parameter logic [N-1:0] LFSR_SEED    = 3'b001,
    parameter logic [S-1:0] MISR_TAPS    = MISR_TAPS_4,
    parameter logic [S-1:0] GOLDEN       = 4'b0000
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  testmode,
    input  logic                                  start,
    input  logic [N-1:0]                          func_in,
    output logic [N-1:0]                          dut_in,
    input  logic [M-1:0]                          dut_out,
    output logic [S-1:0]                          signature,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  fault_detected,
    output logic [clog2(NUM_PATTERNS+1)-1:0]      pattern_count
);

    localparam int           CW       = clog2(NUM_PATTERNS + 1);
    localparam logic [CW-1:0] LAST    = CW'(NUM_PATTERNS);
    // an all-zero seed would lock the LFSR up
    localparam logic [N-1:0] SEED_EFF = (LFSR_SEED == '0) ? N'(1) : LFSR_SEED;

    state_e        state_q, state_d;
    logic [N-1:0]  lfsr_q, lfsr_d, lfsr_step;
    logic [CW-1:0] count_q, count_d, count_inc;
    logic          fault_q, fault_d;
    logic          misr_clr, misr_en;

    assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        count_d  = count_q;
        fault_d  = fault_q;
        misr_clr = 1'b0;
        misr_en  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    lfsr_d   = SEED_EFF;
                    count_d  = '0;
                    fault_d  = 1'b0;
                    misr_clr = 1'b1;
                end
            end
            RUN: begin
                // response to the current pattern is captured as the LFSR advances
                misr_en = 1'b1;
                lfsr_d  = lfsr_step;
                count_d = count_inc;
                if (count_inc == LAST) state_d = COMPARE;
            end
            COMPARE: begin
                fault_d = (signature != GOLDEN);
                state_d = DONE;
            end
            DONE: begin
                // start must drop before another run can be requested
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // leaving test mode aborts everything; a fault is never reported
        // outside test mode
        if (!testmode) begin
            state_d  = IDLE;
            lfsr_d   = lfsr_q;
            count_d  = count_q;
            fault_d  = 1'b0;
            misr_clr = 1'b0;
            misr_en  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            lfsr_q  <= SEED_EFF;
            count_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            count_q <= count_d;
            fault_q <= fault_d;
        end
    end

    misr_n #(
        .S         (S),
        .M         (M),
        .MISR_TAPS (MISR_TAPS)
    ) u_misr (
        .clock (clock),
        .reset (reset),
        .clear (misr_clr),
        .en    (misr_en),
        .din   (dut_out),
        .sig   (signature)
    );

    assign dut_in         = testmode ? lfsr_q : func_in;
    assign busy           = (state_q == RUN) || (state_q == COMPARE);
    assign done           = (state_q == DONE);
    assign fault_detected = fault_q;
    assign pattern_count  = count_q;

endmodule

// File: tb/tb_bist_engine.sv
module tb_bist_engine;

    logic       clock = 1'b0;
    logic       reset, testmode, start, stuck;
    logic [2:0] func_in;
    logic [1:0] zero_resp, fa_resp;

    // full-adder DUT instance (GOLDEN = hand-computed fault-free signature)
    logic [2:0] fa_din, fa_cnt;
    logic [3:0] fa_sig;
    logic       fa_busy, fa_done, fa_fault;
    // zero-response instances with two different goldens
    logic [2:0] z0_din, z0_cnt, z3_din, z3_cnt;
    logic [3:0] z0_sig, z3_sig;
    logic       z0_busy, z0_done, z0_fault, z3_busy, z3_done, z3_fault;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    assign zero_resp = 2'b00;
    // dut_in = {a, b, cin}; response = {cout, sum}
    assign fa_resp = {stuck ? 1'b0 : ((fa_din[2] & fa_din[1]) | (fa_din[2] & fa_din[0]) | (fa_din[1] & fa_din[0])),
                      ^fa_din};

    bist_engine #(.GOLDEN(4'b0110)) u_fa (
        .clock(clock), .reset(reset), .testmode(testmode), .start(start),
        .func_in(func_in), .dut_in(fa_din), .dut_out(fa_resp), .signature(fa_sig),
        .busy(fa_busy), .done(fa_done), .fault_detected(fa_fault), .pattern_count(fa_cnt));

    bist_engine #(.GOLDEN(4'b0000)) u_z0 (
        .clock(clock), .reset(reset), .testmode(testmode), .start(start),
        .func_in(func_in), .dut_in(z0_din), .dut_out(zero_resp), .signature(z0_sig),
        .busy(z0_busy), .done(z0_done), .fault_detected(z0_fault), .pattern_count(z0_cnt));

    bist_engine #(.GOLDEN(4'b0011)) u_z3 (
        .clock(clock), .reset(reset), .testmode(testmode), .start(start),
        .func_in(func_in), .dut_in(z3_din), .dut_out(zero_resp), .signature(z3_sig),
        .busy(z3_busy), .done(z3_done), .fault_detected(z3_fault), .pattern_count(z3_cnt));

    typedef struct packed {
        logic       start;
        logic [2:0] din;
        logic [2:0] cnt;
        logic       busy;
        logic       done;
        logic       fault;
        logic [3:0] sig;
    } vec_t;

    vec_t tbl [9];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // one clean full-adder run from IDLE, checked cycle by cycle against the table
    task automatic run_table(input string tag);
        for (int k = 0; k < 9; k++) begin
            start = tbl[k].start;
            tick();
            chk($sformatf("%s[%0d].dut_in", tag, k), 32'(fa_din), 32'(tbl[k].din));
            chk($sformatf("%s[%0d].count", tag, k), 32'(fa_cnt), 32'(tbl[k].cnt));
            chk($sformatf("%s[%0d].busy", tag, k), 32'(fa_busy), 32'(tbl[k].busy));
            chk($sformatf("%s[%0d].done", tag, k), 32'(fa_done), 32'(tbl[k].done));
            chk($sformatf("%s[%0d].fault", tag, k), 32'(fa_fault), 32'(tbl[k].fault));
            chk($sformatf("%s[%0d].sig", tag, k), 32'(fa_sig), 32'(tbl[k].sig));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // record k = state seen after the k-th edge counted from the start edge
        //            start  dut_in  cnt   busy  done  fault sig
        tbl[0] = '{1'b1, 3'b001, 3'd0, 1'b1, 1'b0, 1'b0, 4'b0000};
        tbl[1] = '{1'b0, 3'b110, 3'd1, 1'b1, 1'b0, 1'b0, 4'b0001};
        tbl[2] = '{1'b0, 3'b011, 3'd2, 1'b1, 1'b0, 1'b0, 4'b0000};
        tbl[3] = '{1'b0, 3'b111, 3'd3, 1'b1, 1'b0, 1'b0, 4'b0010};
        tbl[4] = '{1'b0, 3'b101, 3'd4, 1'b1, 1'b0, 1'b0, 4'b0111};
        tbl[5] = '{1'b0, 3'b100, 3'd5, 1'b1, 1'b0, 1'b0, 4'b1100};
        tbl[6] = '{1'b0, 3'b010, 3'd6, 1'b1, 1'b0, 1'b0, 4'b1010};
        tbl[7] = '{1'b0, 3'b001, 3'd7, 1'b1, 1'b0, 1'b0, 4'b0110};
        tbl[8] = '{1'b0, 3'b001, 3'd7, 1'b0, 1'b1, 1'b0, 4'b0110};

        reset = 1'b1; testmode = 1'b0; start = 1'b0; stuck = 1'b0; func_in = 3'b101;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("reset.dut_in_func", 32'(fa_din), 32'h5);
        chk("reset.sig", 32'(fa_sig), 32'h0);
        chk("reset.count", 32'(fa_cnt), 32'h0);
        chk("reset.busy", 32'(fa_busy), 32'h0);
        chk("reset.done", 32'(fa_done), 32'h0);
        chk("reset.fault", 32'(fa_fault), 32'h0);
        testmode = 1'b1;
        #1;
        chk("idle.dut_in_seed", 32'(fa_din), 32'h1);

        // clean run: LFSR sequence, count, done timing, full-adder signature
        run_table("clean");
        chk("zero.g0.sig", 32'(z0_sig), 32'h0);
        chk("zero.g0.fault", 32'(z0_fault), 32'h0);
        chk("zero.g3.sig", 32'(z3_sig), 32'h0);
        chk("zero.g3.fault", 32'(z3_fault), 32'h1);
        chk("zero.g3.done", 32'(z3_done), 32'h1);
        tick();
        chk("back_idle.done", 32'(fa_done), 32'h0);
        chk("back_idle.busy", 32'(fa_busy), 32'h0);

        // stuck-at-0 cout with start held high through DONE
        stuck = 1'b1;
        start = 1'b1;
        repeat (9) tick();
        chk("stuck.done", 32'(fa_done), 32'h1);
        chk("stuck.sig", 32'(fa_sig), 32'h7);
        chk("stuck.fault", 32'(fa_fault), 32'h1);
        repeat (4) tick();
        chk("hold.done", 32'(fa_done), 32'h1);
        chk("hold.busy", 32'(fa_busy), 32'h0);
        chk("hold.count", 32'(fa_cnt), 32'h7);
        chk("hold.sig", 32'(fa_sig), 32'h7);
        start = 1'b0;
        tick();
        chk("drop.done", 32'(fa_done), 32'h0);
        chk("drop.fault_held", 32'(fa_fault), 32'h1);
        tick();
        chk("idle.fault_held", 32'(fa_fault), 32'h1);
        // new run must clear the fault on its start edge (table row 0)
        stuck = 1'b0;
        run_table("rerun");
        tick();

        // abort on RUN cycle 3
        start = 1'b1; tick();
        start = 1'b0; tick(); tick();
        chk("abort.pre_count", 32'(fa_cnt), 32'h2);
        testmode = 1'b0; func_in = 3'b110;
        tick();
        chk("abort.busy", 32'(fa_busy), 32'h0);
        chk("abort.done", 32'(fa_done), 32'h0);
        chk("abort.fault", 32'(fa_fault), 32'h0);
        chk("abort.dut_in_func", 32'(fa_din), 32'h6);
        testmode = 1'b1;
        run_table("after_abort");
        tick();

        // abort from DONE with a fault pending: fault must clear
        stuck = 1'b1; start = 1'b1;
        repeat (9) tick();
        chk("abort_done.pre_fault", 32'(fa_fault), 32'h1);
        start = 1'b0; testmode = 1'b0;
        tick();
        chk("abort_done.fault", 32'(fa_fault), 32'h0);
        chk("abort_done.done", 32'(fa_done), 32'h0);
        stuck = 1'b0; testmode = 1'b1;
        tick();

        // reset on RUN cycle 4
        start = 1'b1; tick();
        start = 1'b0; tick(); tick(); tick();
        chk("rst.pre_count", 32'(fa_cnt), 32'h3);
        reset = 1'b1;
        tick();
        chk("rst.busy", 32'(fa_busy), 32'h0);
        chk("rst.done", 32'(fa_done), 32'h0);
        chk("rst.fault", 32'(fa_fault), 32'h0);
        chk("rst.sig", 32'(fa_sig), 32'h0);
        chk("rst.count", 32'(fa_cnt), 32'h0);
        chk("rst.dut_in_seed", 32'(fa_din), 32'h1);
        reset = 1'b0;
        run_table("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
